stopwatch_time_core: RTL
========================

// Module: stopwatch_time_core
// PURPOSE
//  Consumes the slow square-wave tick from the upstream clock divider and keeps stopwatch time as MM:SS BCD digits.
//  Supports run/pause, clear and manual adjust, and feeds the display-mux stage downstream.
//  Runs entirely in the src_clk domain. tick_in is synchronised and edge-detected locally.
// PARAMETERS
//  TICKS_PER_SEC  4  rising edges of tick_in per counted second (>=1)
//  ADJ_DIV        2  rising edges of tick_in per field increment in adjust mode (>=1)
// PORTS
//  src_clk     in   1  system clock
//  src_rst_n   in   1  asynchronous active-low reset
//  tick_in     in   1  divider square wave; only rising edges count
//  run_toggle  in   1  1-cycle pulse: start/pause
//  clr         in   1  1-cycle pulse: zero time and sub-second count
//  adj_en      in   1  level: adjust mode while high
//  adj_sel     in   1  adjust field: 0=seconds, 1=minutes
//  min_tens    out  4  BCD 0-5
//  min_ones    out  4  BCD 0-9
//  sec_tens    out  4  BCD 0-5
//  sec_ones    out  4  BCD 0-9
//  running     out  1  high in RUN state
//  blink       out  1  toggles on every tick in ADJ; 0 otherwise
// BEHAVIOUR
//  Reset (async, src_rst_n=0): all digits 0, running=0, blink=0, state=IDLE, sub-second and adjust counters 0, sync/edge flops 0.
//  Tick path: 2-flop synchroniser, then an edge register.
//   tick = sync2 & ~prev, one cycle wide.
//   A tick_in rise sampled at edge N makes tick high after edge N+1. Digits update at edge N+2.
//  States: IDLE (paused), RUN, ADJ.
//   IDLE: run_toggle -> RUN. adj_en=1 -> ADJ. Ticks are ignored.
//   RUN: run_toggle -> IDLE. adj_en=1 -> ADJ.
//   ADJ: adj_en=0 -> IDLE. run_toggle is ignored.
//  Priority on the same cycle: clr > adj_en > run_toggle.
//  clr zeroes digits and the sub-second count and keeps the state, except with the saturate feature (see CONFIGURATION).
//  Entering ADJ clears the adjust counter and blink.
//  RUN counting:
//   Each tick increments subsec (width $clog2(TICKS_PER_SEC), min 1).
//   At subsec==TICKS_PER_SEC-1, subsec wraps to 0 and seconds advance.
//   sec_ones 9->0 carries to sec_tens. sec_tens 5->0 carries to min_ones. min_ones 9->0 carries to min_tens.
//   59:59 -> 00:00 (wrap).
//   subsec is retained across pause, so resume continues the fractional second.
//  ADJ counting:
//   Each tick toggles blink and increments the adjust counter.
//   At ADJ_DIV-1, the counter wraps and the selected field increments by 1.
//   Fields run 00..59 and wrap to 00 with no carry into the other field.
//   Changing adj_sel mid-ADJ takes effect at the next increment. The adjust counter is not reset.
//  Simultaneous events:
//   A tick arriving on the same cycle as a state change is applied under the old state.
//   clr with a tick: clr wins and the tick is discarded.
//  All outputs are registered. Digits never hold non-BCD values.
// CONFIGURATION
//  STOPWATCH_SATURATE_EN defined:
//   In RUN, a carry out of 59:59 holds 59:59 and forces IDLE (running drops on that same edge).
//   run_toggle in IDLE while at 59:59 is ignored until clr or an adjust moves the time.
//   ADJ field wrap is unchanged.
//  STOPWATCH_SATURATE_EN undefined: 59:59 wraps to 00:00 and RUN continues.
// TESTING
//  All scenarios use TICKS_PER_SEC=4 and ADJ_DIV=2, with tick_in toggling every 10 src_clk cycles.
//  1. Reset, then 8 tick_in rises with state IDLE -> digits stay 00:00, running=0, blink=0.
//  2. run_toggle, then 4 rises -> 00:01; 40 rises -> 00:10; digit change lands 2 cycles after the sampling edge.
//  3. Preload 59:58 via ADJ, then RUN for 8 rises -> 00:00 (macro off), or 59:59 with running=0 (macro on).
//  4. RUN for 2 rises, pause, 10 rises, resume, 2 rises -> exactly 00:01 (subsec retained).
//  5. adj_en=1, adj_sel=1, 6 rises -> min 03, seconds unchanged, blink toggled 6 times, back to 0 on exit.
//  6. clr asserted on the same cycle as a tick in RUN at 12:34 -> 00:00, running=1, next second after 4 more rises.
//  7. Deassert src_rst_n mid-RUN, asynchronously to src_clk -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/stopwatch_time_core.sv
// stopwatch_time_core: MM:SS BCD stopwatch counted from a divided tick; define STOPWATCH_SATURATE_EN to hold at 59:59 instead of wrapping.
module stopwatch_time_core #(
    parameter int TICKS_PER_SEC = 4,
    parameter int ADJ_DIV       = 2
) (
    input  logic       src_clk,
    input  logic       src_rst_n,
    input  logic       tick_in,
    input  logic       run_toggle,
    input  logic       clr,
    input  logic       adj_en,
    input  logic       adj_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blink
);
    localparam int SW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam int AW = ADJ_DIV > 1 ? $clog2(ADJ_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, ADJ} state_t;

    state_t        state, state_d;
    logic          sync1, sync2, prev, tick, hold, blink_d;
    logic [SW-1:0] subsec, subsec_d;
    logic [AW-1:0] adj_cnt, adj_d;
    logic [15:0]   tm, tm_d;

    // Advance one MM or SS field 00..59, wrapping to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] f);
        return f[3:0] == 4'd9 ? {(f[7:4] == 4'd5 ? 4'd0 : f[7:4] + 4'd1), 4'd0}
                              : {f[7:4], f[3:0] + 4'd1};
    endfunction

    assign tick = sync2 & ~prev;
    assign {min_tens, min_ones, sec_tens, sec_ones} = tm;

`ifdef STOPWATCH_SATURATE_EN
    assign hold = tm == 16'h5959;
`else
    assign hold = 1'b0;
`endif

    // Next time, sub-second, adjust and state values; a tick is applied under the current state.
    always_comb begin
        state_d  = state;
        tm_d     = tm;
        subsec_d = subsec;
        adj_d    = adj_cnt;
        blink_d  = blink;
        if (clr) begin
            tm_d     = '0;
            subsec_d = '0;
        end else begin
            if (tick && state == RUN) begin
                subsec_d = subsec == SW'(TICKS_PER_SEC - 1) ? '0 : subsec + SW'(1);
                if (subsec == SW'(TICKS_PER_SEC - 1)) begin
                    tm_d[7:0] = bcd_inc(tm[7:0]);
                    if (tm[7:0] == 8'h59) tm_d[15:8] = bcd_inc(tm[15:8]);
                    if (hold) begin
                        tm_d    = tm;
                        state_d = IDLE;
                    end
                end
            end
            if (tick && state == ADJ) begin
                blink_d = ~blink;
                adj_d   = adj_cnt == AW'(ADJ_DIV - 1) ? '0 : adj_cnt + AW'(1);
                if (adj_cnt == AW'(ADJ_DIV - 1)) begin
                    if (adj_sel) tm_d[15:8] = bcd_inc(tm[15:8]);
                    else tm_d[7:0] = bcd_inc(tm[7:0]);
                end
            end
            if (state == ADJ) state_d = adj_en ? ADJ : IDLE;
            else if (adj_en) state_d = ADJ;
            else if (run_toggle) state_d = (state == RUN || hold) ? IDLE : RUN;
            if (state != ADJ && state_d == ADJ) begin
                adj_d   = '0;
                blink_d = 1'b0;
            end
            if (state_d != ADJ) blink_d = 1'b0;
        end
    end

    // Tick synchroniser, edge register and all architectural state.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            state   <= IDLE;
            tm      <= '0;
            subsec  <= '0;
            adj_cnt <= '0;
            blink   <= 1'b0;
            running <= 1'b0;
        end else begin
            sync1   <= tick_in;
            sync2   <= sync1;
            prev    <= sync2;
            state   <= state_d;
            tm      <= tm_d;
            subsec  <= subsec_d;
            adj_cnt <= adj_d;
            blink   <= blink_d;
            running <= state_d == RUN;
        end
    end
endmodule
